// File: rtl/maria_pkg.sv
// Shared types and default timing constants for the Maria DMA scheduler.
package maria_pkg;

  localparam int unsigned HALT_LAT_DEF = 4;
  localparam int unsigned NMI_LEN_DEF  = 8;
  localparam int unsigned CNT_W_DEF    = 4;

  typedef enum logic [2:0] {
    IDLE,
    DLL_HALT,
    DLL_FETCH,
    WAIT_HBS,
    LINE_HALT,
    LINE_DMA,
    ZONE_DLL,
    WAIT_LRC
  } sched_state_t;

endpackage

// File: rtl/maria_dma_sched_if.sv
// Timing strobes, DMA engine handshake and CPU halt/NMI lines around the scheduler.
interface maria_dma_sched_if;
  logic mclk1;
  logic dma_en;
  logic vbe;
  logic hbs;
  logic lrc;
  logic vblank;
  logic dll_done;
  logic line_done;
  logic zone_last;
  logic dli_req;
  logic halt_n;
  logic dll_start;
  logic line_start;
  logic buf_swap;
  logic nmi_n;
  logic overrun;

  modport master (
    input  mclk1, dma_en, vbe, hbs, lrc, vblank,
    input  dll_done, line_done, zone_last, dli_req,
    output halt_n, dll_start, line_start, buf_swap, nmi_n, overrun
  );

  modport slave (
    output mclk1, dma_en, vbe, hbs, lrc, vblank,
    output dll_done, line_done, zone_last, dli_req,
    input  halt_n, dll_start, line_start, buf_swap, nmi_n, overrun
  );
endinterface

// File: rtl/maria_pulse_timer.sv
// Loadable down-counter producing an active-low pulse of len enabled ticks.
// A load arriving while a pulse is running is ignored.
module maria_pulse_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             pulse_n
);

  logic [CNT_W-1:0] cnt;

  // Count down the remaining low ticks; release pulse_n on the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pulse_n <= 1'b1;
    end else if (en) begin
      if (cnt == '0) begin
        if (load && (len != '0)) begin
          cnt     <= len;
          pulse_n <= 1'b0;
        end
      end else begin
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) pulse_n <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/maria_dma_sched.sv
// Per-line DMA sequencer: halts the CPU, kicks DLL and line DMA, swaps line
// buffers and raises the DLI NMI. All state advances on mclk1 ticks only.
module maria_dma_sched
  import maria_pkg::*;
#(
  parameter int unsigned HALT_LAT = HALT_LAT_DEF,
  parameter int unsigned NMI_LEN  = NMI_LEN_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input logic               clk,
  input logic               reset,
  maria_dma_sched_if.master bus
);

  sched_state_t     state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             halt_q, halt_d;
  logic             dll_q, dll_d;
  logic             line_q, line_d;
  logic             swap_q, swap_d;
  logic             ovr_q, ovr_d;
  logic             pend_q, pend_d;
  logic             vbl_q;
  logic             nmi_req;
  logic             abort;

  assign abort = !bus.dma_en || (bus.vblank && !vbl_q);

  // Register state, halt counter and all outputs on each mclk1 tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      halt_q <= 1'b1;
      dll_q  <= 1'b0;
      line_q <= 1'b0;
      swap_q <= 1'b0;
      ovr_q  <= 1'b0;
      pend_q <= 1'b0;
      vbl_q  <= 1'b0;
    end else if (bus.mclk1) begin
      state  <= state_d;
      cnt    <= cnt_d;
      halt_q <= halt_d;
      dll_q  <= dll_d;
      line_q <= line_d;
      swap_q <= swap_d;
      ovr_q  <= ovr_d;
      pend_q <= pend_d;
      vbl_q  <= bus.vblank;
    end
  end

  // Next-state and next-output decode; abort outranks every other event.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    halt_d  = halt_q;
    dll_d   = 1'b0;
    line_d  = 1'b0;
    swap_d  = 1'b0;
    ovr_d   = ovr_q;
    pend_d  = pend_q;
    nmi_req = 1'b0;
    if (abort) begin
      state_d = IDLE;
      halt_d  = 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.vbe) begin
          state_d = DLL_HALT;
          ovr_d   = 1'b0;
          halt_d  = 1'b0;
          cnt_d   = '0;
        end
        DLL_HALT: begin
          if (cnt == CNT_W'(HALT_LAT - 1)) begin
            dll_d   = 1'b1;
            state_d = DLL_FETCH;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        DLL_FETCH: if (bus.dll_done) begin
          pend_d  = bus.dli_req;
          halt_d  = 1'b1;
          state_d = WAIT_HBS;
        end
        WAIT_HBS: if (bus.hbs) begin
          halt_d  = 1'b0;
          cnt_d   = '0;
          state_d = LINE_HALT;
        end
        LINE_HALT: begin
          if (bus.lrc) begin
            ovr_d  = 1'b1;
            swap_d = 1'b1;
          end
          if (cnt == CNT_W'(HALT_LAT - 1)) begin
            line_d  = 1'b1;
            state_d = LINE_DMA;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        LINE_DMA: begin
          swap_d = bus.lrc;
          if (bus.line_done) begin
            if (bus.zone_last) begin
              dll_d   = 1'b1;
              state_d = ZONE_DLL;
            end else begin
              halt_d = 1'b1;
              // A coincident lrc is consumed here, so skip the wait for it.
              if (bus.lrc) state_d = bus.vblank ? IDLE : WAIT_HBS;
              else         state_d = WAIT_LRC;
            end
          end else if (bus.lrc) begin
            ovr_d = 1'b1;
          end
        end
        ZONE_DLL: begin
          if (bus.lrc) begin
            ovr_d  = 1'b1;
            swap_d = 1'b1;
          end
          if (bus.dll_done) begin
            nmi_req = pend_q;
            pend_d  = bus.dli_req;
            halt_d  = 1'b1;
            state_d = WAIT_LRC;
          end
        end
        WAIT_LRC: if (bus.lrc) begin
          swap_d  = 1'b1;
          state_d = bus.vblank ? IDLE : WAIT_HBS;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  maria_pulse_timer #(.CNT_W(CNT_W)) u_nmi (
    .clk    (clk),
    .reset  (reset),
    .en     (bus.mclk1),
    .load   (nmi_req),
    .len    (CNT_W'(NMI_LEN)),
    .pulse_n(bus.nmi_n)
  );

  assign bus.halt_n     = halt_q;
  assign bus.dll_start  = dll_q;
  assign bus.line_start = line_q;
  assign bus.buf_swap   = swap_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_maria_dma_sched.sv
// Bench for maria_dma_sched: directed frame walk-through with literal
// expectations, then randomized strobes checked every cycle against a
// tick-level behavioural model.
module tb_maria_dma_sched;

  localparam int HALT_LAT = 4;
  localparam int NMI_LEN  = 8;

  localparam int PH_IDLE = 0, PH_DLL_WAIT = 1, PH_DLL_FETCH = 2, PH_WAIT_HBS = 3,
                 PH_LINE_WAIT = 4, PH_LINE_DMA = 5, PH_ZONE = 6, PH_WAIT_LRC = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  maria_dma_sched_if bus();

  maria_dma_sched #(.HALT_LAT(HALT_LAT), .NMI_LEN(NMI_LEN), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int   m_phase, m_wait, m_nmi_left;
  logic m_halt_n, m_dll, m_line, m_swap, m_ovr, m_pend, m_vbl_prev;

  task automatic model_reset();
    m_phase = PH_IDLE; m_wait = 0; m_nmi_left = 0;
    m_halt_n = 1; m_dll = 0; m_line = 0; m_swap = 0; m_ovr = 0; m_pend = 0; m_vbl_prev = 0;
  endtask

  task automatic model_tick();
    bit nmi_go;
    bit lrc_seen;
    nmi_go = 0;
    lrc_seen = bus.lrc;
    m_dll = 0; m_line = 0; m_swap = 0;
    if (!bus.dma_en || (bus.vblank && !m_vbl_prev)) begin
      m_phase = PH_IDLE;
      m_halt_n = 1;
    end else begin
      // lrc during an active DMA stretch loses the line unless line_done lands with it
      if (lrc_seen && (m_phase == PH_LINE_WAIT || m_phase == PH_ZONE ||
                       (m_phase == PH_LINE_DMA && !bus.line_done))) begin
        m_ovr = 1; m_swap = 1;
      end
      if (m_phase == PH_IDLE) begin
        if (bus.vbe) begin
          m_ovr = 0; m_halt_n = 0; m_wait = HALT_LAT; m_phase = PH_DLL_WAIT;
        end
      end else if (m_phase == PH_DLL_WAIT || m_phase == PH_LINE_WAIT) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          if (m_phase == PH_DLL_WAIT) begin m_dll = 1; m_phase = PH_DLL_FETCH; end
          else begin m_line = 1; m_phase = PH_LINE_DMA; end
        end
      end else if (m_phase == PH_DLL_FETCH) begin
        if (bus.dll_done) begin m_pend = bus.dli_req; m_halt_n = 1; m_phase = PH_WAIT_HBS; end
      end else if (m_phase == PH_WAIT_HBS) begin
        if (bus.hbs) begin m_halt_n = 0; m_wait = HALT_LAT; m_phase = PH_LINE_WAIT; end
      end else if (m_phase == PH_LINE_DMA) begin
        if (bus.line_done) begin
          if (lrc_seen) m_swap = 1;
          if (bus.zone_last) begin
            m_dll = 1; m_phase = PH_ZONE;
          end else begin
            m_halt_n = 0 + 1;
            m_phase = !lrc_seen ? PH_WAIT_LRC : (bus.vblank ? PH_IDLE : PH_WAIT_HBS);
          end
        end
      end else if (m_phase == PH_ZONE) begin
        if (bus.dll_done) begin
          nmi_go = m_pend; m_pend = bus.dli_req; m_halt_n = 1; m_phase = PH_WAIT_LRC;
        end
      end else if (m_phase == PH_WAIT_LRC) begin
        if (lrc_seen) begin m_swap = 1; m_phase = bus.vblank ? PH_IDLE : PH_WAIT_HBS; end
      end
    end
    m_vbl_prev = bus.vblank;
    if (m_nmi_left > 0) m_nmi_left = m_nmi_left - 1;
    else if (nmi_go) m_nmi_left = NMI_LEN;
  endtask

  // Compare process: advance the model on each mclk1 tick, check on the falling edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (reset) model_reset();
      else if (bus.mclk1) model_tick();
      @(negedge clk);
      chk("model_halt_n", bus.halt_n, m_halt_n);
      chk("model_dll_start", bus.dll_start, m_dll);
      chk("model_line_start", bus.line_start, m_line);
      chk("model_buf_swap", bus.buf_swap, m_swap);
      chk("model_overrun", bus.overrun, m_ovr);
      chk("model_nmi_n", bus.nmi_n, (m_nmi_left == 0));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.vbe = 0; bus.hbs = 0; bus.lrc = 0; bus.dll_done = 0; bus.line_done = 0;
    end
  endtask

  logic r_vblank, r_dma;

  initial begin
    bus.mclk1 = 0; bus.dma_en = 1; bus.vbe = 0; bus.hbs = 0; bus.lrc = 1;
    bus.vblank = 0; bus.dll_done = 0; bus.line_done = 0; bus.zone_last = 0; bus.dli_req = 0;

    // Reset with mclk1 toggling
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.mclk1 = ~bus.mclk1;
    end
    chk("rst_halt_n", bus.halt_n, 1'b1);
    chk("rst_nmi_n", bus.nmi_n, 1'b1);
    chk("rst_overrun", bus.overrun, 1'b0);
    chk("rst_pulses", bus.dll_start | bus.line_start | bus.buf_swap, 1'b0);
    reset = 0; bus.mclk1 = 1; bus.lrc = 0;
    tick(2);

    // Frame start
    bus.vbe = 1; tick();
    chk("vbe_halt_low", bus.halt_n, 1'b0);
    tick(3);
    chk("dll_start_early", bus.dll_start, 1'b0);
    tick();
    chk("dll_start_on_time", bus.dll_start, 1'b1);
    tick();
    chk("dll_start_one_tick", bus.dll_start, 1'b0);
    tick(2);
    bus.dll_done = 1; bus.dli_req = 1; tick();
    bus.dli_req = 0;
    chk("dll_done_release", bus.halt_n, 1'b1);

    // Normal line
    bus.hbs = 1; tick();
    chk("hbs_halt_low", bus.halt_n, 1'b0);
    tick(3);
    chk("line_start_early", bus.line_start, 1'b0);
    tick();
    chk("line_start_on_time", bus.line_start, 1'b1);
    tick(35);
    bus.line_done = 1; tick();
    chk("line_done_release", bus.halt_n, 1'b1);
    bus.lrc = 1; tick();
    chk("lrc_swap", bus.buf_swap, 1'b1);
    tick();
    chk("swap_one_tick", bus.buf_swap, 1'b0);

    // Zone end with DLI pending from the first fetch
    bus.hbs = 1; tick();
    tick(4);
    tick(10);
    bus.line_done = 1; bus.zone_last = 1; tick();
    bus.zone_last = 0;
    chk("zone_dll_start", bus.dll_start, 1'b1);
    chk("zone_halt_held", bus.halt_n, 1'b0);
    tick(3);
    bus.dll_done = 1; tick();
    chk("zone_release", bus.halt_n, 1'b1);
    chk("nmi_start", bus.nmi_n, 1'b0);
    for (int i = 0; i < NMI_LEN - 1; i++) begin
      tick();
      chk("nmi_hold", bus.nmi_n, 1'b0);
    end
    tick();
    chk("nmi_end", bus.nmi_n, 1'b1);
    bus.lrc = 1; tick();
    chk("zone_lrc_swap", bus.buf_swap, 1'b1);

    // Overrun
    bus.hbs = 1; tick();
    tick(9);
    bus.lrc = 1; tick();
    chk("ovr_set", bus.overrun, 1'b1);
    chk("ovr_swap", bus.buf_swap, 1'b1);
    chk("ovr_halt_held", bus.halt_n, 1'b0);
    tick();
    chk("ovr_sticky", bus.overrun, 1'b1);

    // vblank rising in LINE_DMA aborts; next vbe clears overrun
    bus.vblank = 1; tick();
    chk("abort_halt", bus.halt_n, 1'b1);
    chk("abort_ovr_kept", bus.overrun, 1'b1);
    bus.vblank = 0; tick();
    bus.vbe = 1; tick();
    chk("vbe_clears_ovr", bus.overrun, 1'b0);
    chk("vbe2_halt_low", bus.halt_n, 1'b0);
    bus.dma_en = 0; tick();
    chk("dma_off_halt", bus.halt_n, 1'b1);
    bus.vbe = 1; tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("dma_off_no_halt", bus.halt_n & !bus.dll_start, 1'b1);
    end
    bus.dma_en = 1;

    // Randomized phase with gated mclk1 and garbage inputs on idle cycles
    r_vblank = 0; r_dma = 1;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(999) < 3);
      bus.mclk1 = ($urandom_range(3) != 0);
      if (bus.mclk1) begin
        if ($urandom_range(149) == 0) r_vblank = ~r_vblank;
        r_dma = ($urandom_range(249) != 0);
        bus.dma_en    = r_dma;
        bus.vblank    = r_vblank;
        bus.lrc       = ($urandom_range(99) < 8);
        bus.hbs       = !bus.lrc && ($urandom_range(99) < 10);
        bus.vbe       = ($urandom_range(99) < 4);
        bus.dll_done  = ($urandom_range(99) < 15);
        bus.line_done = ($urandom_range(99) < 8);
        bus.zone_last = ($urandom_range(99) < 35);
        bus.dli_req   = ($urandom_range(1) == 1);
      end else begin
        bus.dma_en    = $urandom_range(1) == 1;
        bus.vblank    = $urandom_range(1) == 1;
        bus.lrc       = $urandom_range(1) == 1;
        bus.hbs       = $urandom_range(1) == 1;
        bus.vbe       = $urandom_range(1) == 1;
        bus.dll_done  = $urandom_range(1) == 1;
        bus.line_done = $urandom_range(1) == 1;
        bus.zone_last = $urandom_range(1) == 1;
        bus.dli_req   = $urandom_range(1) == 1;
      end
    end
    reset = 0;
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maria_dma_sched.md
Name: maria_dma_sched

Overview:
Per-line DMA sequencer for the Maria video chip. Consumes the timing strobes from the video timing generator (vbe, hbs, lrc, vblank). Sequences display-list-list (DLL) fetches and per-line display-list DMA by halting the CPU, starting and monitoring the DMA engine, swapping line buffers, and raising the display-list interrupt (DLI) NMI.
Sits between the video timing generator, the DMA engine, and the 6502 halt/NMI pins.

Parameters:
HALT_LAT, 4, mclk1 ticks between halt_n falling and the first DMA start (CPU bus release)
NMI_LEN, 8, mclk1 ticks that nmi_n is held low per DLI
CNT_W, 4, width of the internal tick counters; must hold max(HALT_LAT, NMI_LEN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mclk1  in  1  7.16 MHz tick enable; all state advances only when high
dma_en  in  1  CTRL register DMA enable
vbe  in  1  vblank-end strobe (row 16, col 0)
hbs  in  1  hblank-start strobe (col 440)
lrc  in  1  line-reset-count strobe (col 412); also high during reset
vblank  in  1  vertical blank level
dll_done  in  1  DMA engine finished a DLL entry fetch (1-tick pulse)
line_done  in  1  DMA engine finished the line's display lists (1-tick pulse)
zone_last  in  1  current line is the last line of the zone (valid while in LINE_DMA)
dli_req  in  1  DLI bit of the next DLL entry (valid after dll_done)
halt_n  out  1  CPU halt, active low
dll_start  out  1  one-tick pulse: fetch next DLL entry
line_start  out  1  one-tick pulse: run line DMA
buf_swap  out  1  one-tick pulse: swap line buffers
nmi_n  out  1  CPU NMI, active low
overrun  out  1  sticky: line DMA still busy at lrc; cleared at vbe

Behaviour:
- All outputs are registered. Reset values: halt_n=1, nmi_n=1, all pulses=0, overrun=0, state=IDLE.
- Every transition and counter step is gated by mclk1. Pulses last exactly one mclk1 tick.
- States: IDLE, DLL_HALT, DLL_FETCH, WAIT_HBS, LINE_HALT, LINE_DMA, ZONE_DLL, WAIT_LRC.
- IDLE: on vbe & dma_en -> DLL_HALT. Also clear overrun, halt_n=0, counter=0.
- DLL_HALT: count to HALT_LAT-1, then pulse dll_start -> DLL_FETCH.
- DLL_FETCH: on dll_done, latch dli_req into dli_pend, release halt_n, go to WAIT_HBS.
- WAIT_HBS: on hbs, halt_n=0, counter=0 -> LINE_HALT.
- LINE_HALT: after HALT_LAT ticks, pulse line_start -> LINE_DMA.
- LINE_DMA, on line_done:
  - If zone_last=1: pulse dll_start -> ZONE_DLL. Halt stays low.
  - Otherwise: halt_n=1 -> WAIT_LRC.
- ZONE_DLL: on dll_done:
  - If dli_pend (from the previous fetch): start NMI pulse.
  - Then latch the new dli_req, halt_n=1 -> WAIT_LRC.
- WAIT_LRC: on lrc, pulse buf_swap.
  - Next state is WAIT_HBS if vblank=0; otherwise IDLE.
- lrc arriving while in LINE_HALT, LINE_DMA or ZONE_DLL:
  - Set overrun, pulse buf_swap.
  - Stay in the current state; DMA keeps the bus and the line is lost.
- vblank rising or dma_en=0 in any state: go to IDLE next tick, halt_n=1, no pulses issued. An in-flight NMI pulse still completes.
- NMI pulse: nmi_n=0 for exactly NMI_LEN mclk1 ticks, using an independent counter.
  - A new request during an active pulse is dropped, not queued.
- Simultaneous events:
  - hbs and lrc in the same tick cannot occur (cols 440 vs 412).
  - line_done and lrc in the same tick: line_done wins, no overrun, and buf_swap is still pulsed on that lrc.
- reset mid-operation: immediate return to reset values regardless of mclk1.

Decomposition:
- Package maria_pkg holds the state enum (sched_state_t) and the default localparams for HALT_LAT and NMI_LEN.
- One sub-module, maria_pulse_timer: loadable down-counter with a mclk1 enable, producing an active-low pulse of programmable length. Instantiated for nmi_n.
- The halt counter stays inline.

Test Plan:
1. reset=1 for 3 clks with mclk1 toggling -> halt_n=1, nmi_n=1, overrun=0, no pulses.
2. Frame start: dma_en=1, vbe at tick T -> halt_n=0 at T+1, dll_start at T+1+HALT_LAT (T+5), dll_done 3 ticks later -> halt_n=1 the next tick.
3. Normal line: hbs at tick H -> halt_n=0 at H+1, line_start at H+5; line_done at H+40 -> halt_n=1 at H+41; lrc -> one buf_swap pulse, state WAIT_HBS.
4. Zone end with DLI: dli_req=1 on the first fetch, zone_last=1 at line_done -> dll_start pulse; dll_done -> nmi_n low exactly 8 mclk1 ticks, halt_n released on the same tick NMI starts.
5. Overrun: no line_done before lrc -> overrun=1, buf_swap pulsed, halt_n still 0; next vbe clears overrun.
6. Abort: vblank rises while in LINE_DMA -> IDLE next tick, halt_n=1; dma_en=0 at vbe -> no halt for the whole frame.
